// File: rtl/arena_port_arbiter_if.sv
// Arena row port bundle: solver and display-scanner request side plus the arena store side.
`timescale 1ns/1ps
interface arena_port_arbiter_if #(
  parameter int ARENA_WIDTH = 10
);
  logic                   sol_req;
  logic                   sol_gnt;
  logic [7:0]             sol_row_select;
  logic [ARENA_WIDTH-1:0] sol_columns_new;
  logic                   sol_columns_write;
  logic [ARENA_WIDTH-1:0] sol_columns;

  logic                   disp_req;
  logic                   disp_gnt;
  logic [7:0]             disp_row_select;
  logic [ARENA_WIDTH-1:0] disp_columns;

  logic [7:0]             arena_row_select;
  logic [ARENA_WIDTH-1:0] arena_columns;
  logic [ARENA_WIDTH-1:0] arena_columns_new;
  logic                   arena_columns_write;

  // arbiter side
  modport slave (
    input  sol_req, sol_row_select, sol_columns_new, sol_columns_write,
    input  disp_req, disp_row_select, arena_columns,
    output sol_gnt, sol_columns, disp_gnt, disp_columns,
    output arena_row_select, arena_columns_new, arena_columns_write
  );

  // clients and arena store side
  modport master (
    output sol_req, sol_row_select, sol_columns_new, sol_columns_write,
    output disp_req, disp_row_select, arena_columns,
    input  sol_gnt, sol_columns, disp_gnt, disp_columns,
    input  arena_row_select, arena_columns_new, arena_columns_write
  );
endinterface

// File: rtl/arena_port_arbiter.sv
// Arbitrates the single arena row port between solver (rd/wr) and display scanner (rd only).
// Optional macro ARENA_ARB_SOLVER_PRIORITY_EN: solver wins every tie and is never preempted.
//
// state | meaning
// IDLE  | nobody owns the port; also the one-cycle turnaround between owners
// SOL   | solver owns the port, its address/data/strobe reach the arena
// DISP  | display owns the port, read-only access
`timescale 1ns/1ps
module arena_port_arbiter #(
  parameter int ARENA_WIDTH = 10,
  parameter int MAX_BURST   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  arena_port_arbiter_if.slave  port
);

  localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LAST = (MAX_BURST == 0) ? '0 : BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOL  = 2'd1,
    DISP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            sol_gnt_q, disp_gnt_q;
  logic [BW-1:0]   burst_q, burst_d;
  logic            at_limit;
  logic            preempt_sol;
  logic            preempt_disp;
  logic            tie_to_sol;

`ifndef ARENA_ARB_SOLVER_PRIORITY_EN
  logic            last_sol_q;
`endif

  assign at_limit = (MAX_BURST != 0) && (burst_q == BURST_LAST);

  always_comb begin
`ifdef ARENA_ARB_SOLVER_PRIORITY_EN
    tie_to_sol   = 1'b1;
    preempt_sol  = 1'b0;
`else
    tie_to_sol   = !last_sol_q;
    preempt_sol  = at_limit && port.disp_req;
`endif
    preempt_disp = at_limit && port.sol_req;
  end

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    unique case (state_q)
      SOL: begin
        burst_d = (burst_q == BURST_LAST) ? burst_q : burst_q + 1'b1;
        if (!port.sol_req || preempt_sol) state_d = IDLE;
      end
      DISP: begin
        burst_d = (burst_q == BURST_LAST) ? burst_q : burst_q + 1'b1;
        if (!port.disp_req || preempt_disp) state_d = IDLE;
      end
      default: begin
        burst_d = '0;
        if (port.sol_req && port.disp_req) state_d = tie_to_sol ? SOL : DISP;
        else if (port.sol_req)             state_d = SOL;
        else if (port.disp_req)            state_d = DISP;
        else                               state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sol_gnt_q  <= 1'b0;
      disp_gnt_q <= 1'b0;
      burst_q    <= '0;
`ifndef ARENA_ARB_SOLVER_PRIORITY_EN
      last_sol_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sol_gnt_q  <= (state_d == SOL);
      disp_gnt_q <= (state_d == DISP);
      burst_q    <= burst_d;
`ifndef ARENA_ARB_SOLVER_PRIORITY_EN
      // owner is recorded only when a grant starts, so round-robin sees the last real owner
      if (state_q == IDLE && state_d == SOL)       last_sol_q <= 1'b1;
      else if (state_q == IDLE && state_d == DISP) last_sol_q <= 1'b0;
`endif
    end
  end

  // mux follows state_q so a strobe from a non-owner can never reach the arena
  always_comb begin
    port.arena_row_select    = 8'd0;
    port.arena_columns_new   = '0;
    port.arena_columns_write = 1'b0;
    unique case (state_q)
      SOL: begin
        port.arena_row_select    = port.sol_row_select;
        port.arena_columns_new   = port.sol_columns_new;
        port.arena_columns_write = port.sol_columns_write;
      end
      DISP: begin
        port.arena_row_select    = port.disp_row_select;
      end
      default: begin
        port.arena_row_select    = 8'd0;
      end
    endcase
  end

  assign port.sol_gnt      = sol_gnt_q;
  assign port.disp_gnt     = disp_gnt_q;
  assign port.sol_columns  = port.arena_columns;
  assign port.disp_columns = port.arena_columns;

endmodule
